// File: rtl/y86_data_mem.sv
// y86_data_mem: byte-addressable Y86-64 data memory for the memory stage.
// Decodes the access kind, address and store data from icode, holds the
// request for LATENCY cycles, then performs the 8-byte little-endian access
// and reports valM / memerror with a one-cycle done pulse.
module y86_data_mem #(
    parameter int unsigned DEPTH_BYTES = 8192,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        busy,
    output logic        done,
    output logic [63:0] valM,
    output logic        memerror
);

    localparam int unsigned AW       = $clog2(DEPTH_BYTES);
    localparam logic [63:0] MAX_ADDR = 64'(DEPTH_BYTES - 8);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    typedef enum logic [1:0] {
        K_NONE,
        K_READ,
        K_WRITE
    } kind_t;

    logic [7:0]    r_mem [DEPTH_BYTES];

    state_t        r_state;
    state_t        w_next;
    logic          w_accept;
    logic          w_complete;

    kind_t         w_kind;
    logic [63:0]   w_addr;
    logic [63:0]   w_data;
    logic          w_err;

    kind_t         r_kind;
    logic [AW-1:0] r_addr;
    logic [63:0]   r_data;
    logic          r_err;
    logic [3:0]    r_cnt;

    logic          r_done;
    logic [63:0]   r_valM;
    logic          r_memerror;
    logic [63:0]   w_rdata;

    // Decode access kind, address and store data from the live inputs.
    always_comb begin
        w_kind = K_NONE;
        w_addr = valE;
        w_data = valA;
        case (icode)
            4'h4, 4'hA: w_kind = K_WRITE;
            4'h8: begin
                w_kind = K_WRITE;
                w_data = valP;
            end
            4'h5: w_kind = K_READ;
            4'h9, 4'hB: begin
                w_kind = K_READ;
                w_addr = valA;
            end
            default: w_kind = K_NONE;
        endcase
        // Full 64-bit compare so addresses that wrap past 2^64 are caught.
        w_err = (w_kind != K_NONE) && (w_addr > MAX_ADDR);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state: accept in IDLE, complete when the counter runs out.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_complete = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Latch the request, run the latency counter and register the results.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kind     <= K_NONE;
            r_addr     <= '0;
            r_data     <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_valM     <= '0;
            r_memerror <= 1'b0;
        end else begin
            r_done <= w_complete;
            if (w_accept) begin
                r_kind <= w_kind;
                r_addr <= w_addr[AW-1:0];
                r_data <= w_data;
                r_err  <= w_err;
                r_cnt  <= 4'(LATENCY - 1);
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_complete) begin
                r_memerror <= r_err;
                if (r_kind == K_READ) begin
                    r_valM <= r_err ? '0 : w_rdata;
                end
            end
        end
    end

    // Assemble the little-endian read word from the latched address.
    always_comb begin
        w_rdata = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_rdata[8*i +: 8] = r_mem[r_addr + AW'(i)];
        end
    end

    // Commit all 8 store bytes at the completing edge; storage is never reset.
    always_ff @(posedge clk) begin
        if (!reset && w_complete && (r_kind == K_WRITE) && !r_err) begin
            for (int unsigned i = 0; i < 8; i++) begin
                r_mem[r_addr + AW'(i)] <= r_data[8*i +: 8];
            end
        end
    end

    assign busy     = (r_state == S_WAIT);
    assign done     = r_done;
    assign valM     = r_valM;
    assign memerror = r_memerror;

endmodule
